trigger_scheduler: RTL
======================

Name: trigger_scheduler

Overview:
- Collects trigger pulses from up to CHANNELS monoflop instances. The pulses are already synchronized to `clock`.
- Latches each pulse as a pending request.
- Hands pending requests one at a time to the single shared consumer (pulse-sequencer start / timestamp logic) using round-robin arbitration and a valid/ready handshake.
- After each accepted grant, enforces a programmable holdoff before the next grant.

Parameters:
- CHANNELS, 8, number of trigger inputs (2..32).
- HOLDOFF_WIDTH, 16, width of the holdoff counter.
- CW, $clog2(CHANNELS), width of the channel index; derived, not overridden.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable_mask  input  CHANNELS  per-channel enable; 0 ignores that channel's triggers and clears its pending bit.
- trigger_in  input  CHANNELS  monoflop q outputs, synchronous to clock; only rising edges count.
- holdoff  input  HOLDOFF_WIDTH  number of idle cycles inserted after each accepted grant.
- clear_overflow  input  1  single-cycle pulse; clears all overflow bits.
- grant_valid  output  1  a grant is being offered.
- grant_channel  output  CW  channel being offered; meaningful only while grant_valid=1.
- grant_ready  input  1  consumer accepts the offered grant.
- pending  output  CHANNELS  registered pending flags.
- overflow  output  CHANNELS  sticky: a trigger arrived while that channel was already pending.
- busy  output  1  high in OFFER or HOLDOFF state.

Behaviour:
- **Reset**
  - Asynchronous, active-high.
  - Clears pending, overflow, grant_valid, grant_channel, busy, the edge-detect registers and the holdoff counter.
  - Sets FSM to IDLE and the round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - Reset asserted mid-offer or mid-holdoff aborts immediately; the offered request is lost.
- **Edge detect**
  - trig_d <= trigger_in every cycle.
  - edge = trigger_in & ~trig_d & enable_mask.
  - A level held high for many cycles counts once.
- **Pending update, per channel i, each cycle, in priority order:**
  1. enable_mask[i]=0 -> pending[i] <= 0.
  2. Otherwise, if edge[i] occurs in the cycle channel i's grant is accepted -> pending[i] stays 1 (new event), no overflow.
  3. Otherwise, if channel i's grant is accepted -> pending[i] <= 0.
  4. Otherwise, if edge[i]=1 and pending[i]=1 -> overflow[i] <= 1 and pending stays 1.
  5. Otherwise, if edge[i]=1 -> pending[i] <= 1.
- **Overflow clearing**
  - clear_overflow clears all overflow bits.
  - If clear_overflow and a new overflow condition occur in the same cycle, the new overflow wins (bit ends 1).
- **FSM**
  - IDLE:
    - If any pending bit is set, select the first set bit searching from last+1 upward, wrapping modulo CHANNELS.
    - Register grant_channel to that index and grant_valid<=1; go to OFFER.
  - OFFER:
    - grant_valid and grant_channel are held stable until grant_ready=1. This holds even if the offered channel becomes disabled meanwhile; the offer still completes.
    - Handshake cycle (grant_valid & grant_ready): clear pending for that channel (subject to the pending rules above), set last <= grant_channel and grant_valid <= 0.
    - On handshake, if holdoff==0 go to IDLE; otherwise load counter <= holdoff-1 and go to HOLDOFF.
  - HOLDOFF:
    - Counter decrements each cycle; at 0, go to IDLE.
    - Exactly `holdoff` cycles are spent in HOLDOFF.
    - holdoff changes after loading do not affect the running count.
- **Latency**
  - Edge at trigger_in in cycle n -> pending visible n+1 -> grant_valid visible n+2 (when FSM is idle).
  - Back-to-back grants with holdoff=0 are separated by one IDLE cycle (grant_valid low for exactly 1 cycle).
- **busy**: busy = (state != IDLE), registered with the state.
- **No combinational paths** from inputs to grant_valid or grant_channel.

Test Plan:
- **Single trigger:** reset, enable_mask=8'hFF, holdoff=0, grant_ready=1; trigger_in[3] pulsed for 1 cycle at cycle 10 -> pending[3]=1 at 11, grant_valid=1 with grant_channel=3 at 12, pending[3]=0 at 13, no overflow.
- **Round robin:** trigger_in[1], [2] and [5] rise together, grant_ready=1, holdoff=0 -> grants in order 1, 2, 5, each separated by one idle cycle. Then [1] and [5] rise again (last=5) -> order 1, 5.
- **Holdoff and stall:** holdoff=4, grant_ready=0 for 6 cycles while offering channel 0 -> grant_valid and grant_channel stay constant. On accept, busy stays high for 4 cycles, then the next pending channel is offered 1 cycle after HOLDOFF exits.
- **Overflow:** channel 2 triggers twice while its first grant is stalled -> overflow[2]=1 and pending[2]=1. clear_overflow -> overflow[2]=0. An edge in the same cycle as the channel-2 accept -> pending[2] stays 1 and overflow stays 0.
- **Disable:** pending[4]=1 while another channel is offered; enable_mask[4]=0 -> pending[4]=0 next cycle and channel 4 is never granted. A held-high trigger_in[6] (level for 20 cycles) -> exactly one grant.
- **Reset mid-operation:** assert reset during OFFER and again during HOLDOFF -> all outputs 0 immediately (asynchronous). After release, a channel-0 trigger is granted first.

Source files
------------

// File: rtl/trigger_scheduler.sv
// Collects synchronized trigger pulses as pending requests and hands them one at a time
// to a shared consumer using round-robin arbitration, a valid/ready handshake and a holdoff gap.
module trigger_scheduler #(
   parameter int  CHANNELS      = 8,
   parameter int  HOLDOFF_WIDTH = 16,
   localparam int CW            = $clog2(CHANNELS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CHANNELS-1:0]      enable_mask,
   input  logic [CHANNELS-1:0]      trigger_in,
   input  logic [HOLDOFF_WIDTH-1:0] holdoff,
   input  logic                     clear_overflow,
   output logic                     grant_valid,
   output logic [CW-1:0]            grant_channel,
   input  logic                     grant_ready,
   output logic [CHANNELS-1:0]      pending,
   output logic [CHANNELS-1:0]      overflow,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, OFFER, HOLDOFF} state_t;

   state_t                   state_q;
   logic [CHANNELS-1:0]      trig_q;
   logic [CHANNELS-1:0]      pending_q, pending_d;
   logic [CHANNELS-1:0]      overflow_q, overflow_d;
   logic [CHANNELS-1:0]      rise;
   logic [CHANNELS-1:0]      accept_vec;
   logic [CW-1:0]            last_q;
   logic [CW-1:0]            grant_channel_q;
   logic                     grant_valid_q;
   logic                     busy_q;
   logic [HOLDOFF_WIDTH-1:0] cnt_q;
   logic                     accept;
   logic                     sel_found;
   logic [CW-1:0]            sel_idx;

   assign rise       = trigger_in & ~trig_q & enable_mask;
   assign accept     = grant_valid_q & grant_ready;
   assign accept_vec = accept ? (CHANNELS'(1) << grant_channel_q) : '0;

   // A rising edge in the accept cycle is a fresh event, so it keeps the request alive
   // without counting as an overflow.
   always_comb begin
      pending_d  = pending_q;
      overflow_d = clear_overflow ? '0 : overflow_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!enable_mask[i]) begin
            pending_d[i] = 1'b0;
         end else if (rise[i]) begin
            pending_d[i] = 1'b1;
            if (pending_q[i] && !accept_vec[i]) overflow_d[i] = 1'b1;
         end else if (accept_vec[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   // Scan from the farthest offset down so the nearest pending channel after last_q wins.
   always_comb begin
      int c;
      c         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = CHANNELS; k >= 1; k--) begin
         c = int'(last_q) + k;
         if (c >= CHANNELS) c = c - CHANNELS;
         if (pending_q[CW'(c)]) begin
            sel_found = 1'b1;
            sel_idx   = CW'(c);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trig_q     <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
      end else begin
         trig_q     <= trigger_in;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         grant_valid_q   <= 1'b0;
         grant_channel_q <= '0;
         last_q          <= CW'(CHANNELS - 1);
         cnt_q           <= '0;
         busy_q          <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_found) begin
                  grant_channel_q <= sel_idx;
                  grant_valid_q   <= 1'b1;
                  busy_q          <= 1'b1;
                  state_q         <= OFFER;
               end
            end
            OFFER: begin
               if (accept) begin
                  grant_valid_q <= 1'b0;
                  last_q        <= grant_channel_q;
                  if (holdoff == '0) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= holdoff - HOLDOFF_WIDTH'(1);
                     state_q <= HOLDOFF;
                  end
               end
            end
            HOLDOFF: begin
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - HOLDOFF_WIDTH'(1);
               end
            end
            default: begin
               grant_valid_q <= 1'b0;
               busy_q        <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign grant_valid   = grant_valid_q;
   assign grant_channel = grant_channel_q;
   assign pending       = pending_q;
   assign overflow      = overflow_q;
   assign busy          = busy_q;

endmodule
